// File: rtl/bitblade_pkg.sv
// Shared types and helpers for the BitBlade slice scheduler.
// Precision codes, FSM state enum, slice-count and shift helpers.
package bitblade_pkg;

    localparam int SLICE_W    = 2;
    localparam int MAX_SLICES = 4;
    localparam int SHIFT_W    = 4;

    localparam logic [1:0] PREC_2B = 2'd0;
    localparam logic [1:0] PREC_4B = 2'd1;
    localparam logic [1:0] PREC_8B = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Code 3 aliases to 8 b.
    function automatic logic [2:0] prec_to_slices(
        input logic [1:0] code
    );
        logic [2:0] n;
        unique case (code)
            PREC_2B: n = 3'd1;
            PREC_4B: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Highest slice index for a precision code.
    function automatic logic [1:0] prec_to_max(
        input logic [1:0] code
    );
        logic [2:0] n;
        n = prec_to_slices(code) - 3'd1;
        return n[1:0];
    endfunction

    function automatic logic [SHIFT_W-1:0] slice_shift(
        input logic [1:0] i,
        input logic [1:0] w
    );
        logic [2:0] s;
        s = {1'b0, i} + {1'b0, w};
        return SHIFT_W'(int'(s) * SLICE_W);
    endfunction

endpackage

// File: rtl/bitblade_slice_scheduler_if.sv
// Job and beat handshake bundle of the slice scheduler.
// slave: scheduler side; master: layer controller / accumulator side.
interface bitblade_slice_scheduler_if;
    import bitblade_pkg::*;

    logic               job_valid;
    logic               job_ready;
    logic [1:0]         i_prec;
    logic [1:0]         w_prec;
    logic               i_signed;
    logic               w_signed;
    logic               beat_valid;
    logic               beat_ready;
    logic [1:0]         i_slice;
    logic [1:0]         w_slice;
    logic               sign_i;
    logic               sign_w;
    logic [SHIFT_W-1:0] shift;
    logic               first;
    logic               last;
    logic               done;

    modport slave (
        input  job_valid, i_prec, w_prec,
        input  i_signed, w_signed, beat_ready,
        output job_ready, beat_valid,
        output i_slice, w_slice, sign_i, sign_w,
        output shift, first, last, done
    );

    modport master (
        output job_valid, i_prec, w_prec,
        output i_signed, w_signed, beat_ready,
        input  job_ready, beat_valid,
        input  i_slice, w_slice, sign_i, sign_w,
        input  shift, first, last, done
    );

endinterface

// File: rtl/slice_counter2d.sv
// Nested slice counter: i inner, w outer, clear on job start.
// Ports: clr/en controls, i_max/w_max limits, next-value and flag outputs.
module slice_counter2d (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] i_max,
    input  logic [1:0] w_max,
    output logic [1:0] i_nxt,
    output logic [1:0] w_nxt,
    output logic       nxt_first,
    output logic       nxt_last
);

    logic [1:0] i_cnt;
    logic [1:0] w_cnt;

    always_comb begin
        i_nxt = i_cnt;
        w_nxt = w_cnt;
        if (clr) begin
            i_nxt = '0;
            w_nxt = '0;
        end else if (en) begin
            if (i_cnt == i_max) begin
                i_nxt = '0;
                w_nxt = (w_cnt == w_max) ? 2'd0 : w_cnt + 2'd1;
            end else begin
                i_nxt = i_cnt + 2'd1;
            end
        end
    end

    assign nxt_first = (i_nxt == 2'd0) && (w_nxt == 2'd0);
    assign nxt_last  = (i_nxt == i_max) && (w_nxt == w_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt <= '0;
            w_cnt <= '0;
        end else begin
            i_cnt <= i_nxt;
            w_cnt <= w_nxt;
        end
    end

endmodule

// File: rtl/bitblade_slice_scheduler.sv
// Sequences one multi-precision multiply job as 2-bit slice-pair beats.
// Ports: clk, rst_n (async, active-low), bus (job in, beats/done out).
module bitblade_slice_scheduler
    import bitblade_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    bitblade_slice_scheduler_if.slave   bus
);

    state_t     state;
    logic [1:0] i_max_q;
    logic [1:0] w_max_q;
    logic       i_sgn_q;
    logic       w_sgn_q;

    logic       idle;
    logic       accept;
    logic       step;
    logic       load;
    logic [1:0] i_max;
    logic [1:0] w_max;
    logic       i_sgn;
    logic       w_sgn;
    logic [1:0] i_nxt;
    logic [1:0] w_nxt;
    logic       nxt_first;
    logic       nxt_last;

    assign idle   = (state == S_IDLE);
    assign accept = bus.job_valid && bus.job_ready;
    assign step   = bus.beat_valid && bus.beat_ready;
    // Load the beat registers on job start or on any non-final advance.
    assign load   = accept || (step && !bus.last);

    // While idle, limits come straight from the request so the first
    // beat can be registered in the accept cycle.
    assign i_max = idle ? prec_to_max(bus.i_prec) : i_max_q;
    assign w_max = idle ? prec_to_max(bus.w_prec) : w_max_q;
    assign i_sgn = idle ? bus.i_signed : i_sgn_q;
    assign w_sgn = idle ? bus.w_signed : w_sgn_q;

    slice_counter2d u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (accept),
        .en        (step),
        .i_max     (i_max),
        .w_max     (w_max),
        .i_nxt     (i_nxt),
        .w_nxt     (w_nxt),
        .nxt_first (nxt_first),
        .nxt_last  (nxt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            i_max_q        <= '0;
            w_max_q        <= '0;
            i_sgn_q        <= 1'b0;
            w_sgn_q        <= 1'b0;
            bus.job_ready  <= 1'b1;
            bus.beat_valid <= 1'b0;
            bus.i_slice    <= '0;
            bus.w_slice    <= '0;
            bus.sign_i     <= 1'b0;
            bus.sign_w     <= 1'b0;
            bus.shift      <= '0;
            bus.first      <= 1'b0;
            bus.last       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        i_max_q        <= i_max;
                        w_max_q        <= w_max;
                        i_sgn_q        <= i_sgn;
                        w_sgn_q        <= w_sgn;
                        bus.job_ready  <= 1'b0;
                        bus.beat_valid <= 1'b1;
                        state          <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (step && bus.last) begin
                        bus.beat_valid <= 1'b0;
                        bus.done       <= 1'b1;
                        state          <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.job_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (load) begin
                bus.i_slice <= i_nxt;
                bus.w_slice <= w_nxt;
                bus.sign_i  <= i_sgn && (i_nxt == i_max);
                bus.sign_w  <= w_sgn && (w_nxt == w_max);
                bus.shift   <= slice_shift(i_nxt, w_nxt);
                bus.first   <= nxt_first;
                bus.last    <= nxt_last;
            end else if (step && bus.last) begin
                bus.i_slice <= '0;
                bus.w_slice <= '0;
                bus.sign_i  <= 1'b0;
                bus.sign_w  <= 1'b0;
                bus.shift   <= '0;
                bus.first   <= 1'b0;
                bus.last    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bitblade_slice_scheduler.sv
// Self-checking bench for bitblade_slice_scheduler.
// Expected beats are queued per job and compared as the DUT emits them.
module tb_bitblade_slice_scheduler;
    import bitblade_pkg::*;

    typedef struct packed {
        logic [1:0] i;
        logic [1:0] w;
        logic [3:0] sh;
        logic       si;
        logic       sw;
        logic       f;
        logic       l;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bitblade_slice_scheduler_if bus();

    bitblade_slice_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    total = 0;
    int    bad = 0;
    beat_t sb[$];

    function automatic beat_t observe();
        beat_t b;
        b.i  = bus.i_slice;
        b.w  = bus.w_slice;
        b.sh = bus.shift;
        b.si = bus.sign_i;
        b.sw = bus.sign_w;
        b.f  = bus.first;
        b.l  = bus.last;
        return b;
    endfunction

    function automatic logic [14:0] idle_vec();
        return {bus.job_ready, bus.beat_valid, bus.done,
                bus.first, bus.last, bus.sign_i, bus.sign_w,
                bus.i_slice, bus.w_slice, bus.shift};
    endfunction

    task automatic model_push(input logic [1:0] ip, input logic [1:0] wp,
                              input logic is, input logic ws);
        int    ni;
        int    nw;
        beat_t e;
        ni = (ip == 2'd0) ? 1 : (ip == 2'd1) ? 2 : 4;
        nw = (wp == 2'd0) ? 1 : (wp == 2'd1) ? 2 : 4;
        for (int w = 0; w < nw; w++) begin
            for (int i = 0; i < ni; i++) begin
                e.i  = 2'(i);
                e.w  = 2'(w);
                e.sh = 4'(2 * (i + w));
                e.si = is && (i == ni - 1);
                e.sw = ws && (w == nw - 1);
                e.f  = (i == 0) && (w == 0);
                e.l  = (i == ni - 1) && (w == nw - 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic issue(input logic [1:0] ip, input logic [1:0] wp,
                         input logic is, input logic ws, input bit hold);
        @(negedge clk);
        bus.i_prec    = ip;
        bus.w_prec    = wp;
        bus.i_signed  = is;
        bus.w_signed  = ws;
        bus.job_valid = 1'b1;
        for (int k = 0; k < 50 && !bus.job_ready; k++) @(negedge clk);
        total++;
        if (bus.job_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_wait: job_ready=%b want 1", bus.job_ready);
        end
        @(posedge clk);
        #1;
        if (!hold) bus.job_valid = 1'b0;
    endtask

    task automatic drain(input bit toggle, input int stop_beats,
                         input int want_done, output int ndone,
                         output int done_cyc, output int acc_cyc);
        beat_t held;
        beat_t cur;
        beat_t e;
        bit    hv;
        bit    drop;
        bit    fin;
        int    pops;
        hv = 0; drop = 0; fin = 0; pops = 0;
        ndone = 0; done_cyc = 0; acc_cyc = 0;
        for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
            @(negedge clk);
            if (drop) begin
                bus.job_valid = 1'b0;
                drop = 0;
            end
            bus.beat_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            cur = observe();
            if (hv) begin
                total++;
                if (bus.beat_valid !== 1'b1 || cur !== held) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%b %h want v=1 %h",
                             bus.beat_valid, cur, held);
                end
                hv = 0;
            end
            if (bus.job_valid && bus.job_ready) begin
                acc_cyc = cyc;
                drop = 1;
            end
            if (bus.beat_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got %h want none", cur);
                end else if (bus.beat_ready) begin
                    e = sb.pop_front();
                    pops++;
                    total++;
                    if (cur !== e) begin
                        bad++;
                        $display("FAIL beat%0d: got %h want %h",
                                 pops - 1, cur, e);
                    end
                end else begin
                    held = cur;
                    hv = 1;
                end
            end
            if (bus.done) begin
                ndone++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (stop_beats > 0 && pops == stop_beats) fin = 1;
            if (stop_beats == 0 && ndone == want_done && sb.size() == 0)
                fin = 1;
        end
        total++;
        if (!fin) begin
            bad++;
            $display("FAIL drain_timeout: pops=%0d done=%0d left=%0d",
                     pops, ndone, sb.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (idle_vec() !== 15'h4000) begin
            bad++;
            $display("FAIL reset_vals: got %h want 4000", idle_vec());
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (idle_vec() !== 15'h4000) begin
            bad++;
            $display("FAIL post_reset: got %h want 4000", idle_vec());
        end
    endtask

    task automatic test_unsigned_2b();
        int nd, dc, ac;
        model_push(2'd0, 2'd0, 1'b0, 1'b0);
        issue(2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        drain(1'b0, 0, 1, nd, dc, ac);
        total++;
        if (nd != 1 || dc != 2) begin
            bad++;
            $display("FAIL u2b_done: got n=%0d cyc=%0d want n=1 cyc=2",
                     nd, dc);
        end
    endtask

    task automatic test_signed_4b();
        int nd, dc, ac;
        model_push(2'd1, 2'd1, 1'b1, 1'b1);
        issue(2'd1, 2'd1, 1'b1, 1'b1, 1'b0);
        drain(1'b0, 0, 1, nd, dc, ac);
        total++;
        if (nd != 1 || dc != 5) begin
            bad++;
            $display("FAIL s4b_done: got n=%0d cyc=%0d want n=1 cyc=5",
                     nd, dc);
        end
    endtask

    task automatic test_8x2();
        int nd, dc, ac;
        model_push(2'd2, 2'd0, 1'b1, 1'b0);
        issue(2'd2, 2'd0, 1'b1, 1'b0, 1'b0);
        drain(1'b0, 0, 1, nd, dc, ac);
        total++;
        if (nd != 1 || dc != 5) begin
            bad++;
            $display("FAIL 8x2_done: got n=%0d cyc=%0d want n=1 cyc=5",
                     nd, dc);
        end
    endtask

    task automatic test_8x8_stall();
        int nd, dc, ac;
        model_push(2'd2, 2'd2, 1'b1, 1'b1);
        issue(2'd2, 2'd2, 1'b1, 1'b1, 1'b0);
        drain(1'b1, 0, 1, nd, dc, ac);
        total++;
        if (nd != 1 || dc != 32) begin
            bad++;
            $display("FAIL 8x8_done: got n=%0d cyc=%0d want n=1 cyc=32",
                     nd, dc);
        end
        bus.beat_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (bus.done !== 1'b0 || bus.beat_valid !== 1'b0) begin
                bad++;
                $display("FAIL 8x8_after: got done=%b v=%b want 0 0",
                         bus.done, bus.beat_valid);
            end
        end
    endtask

    task automatic test_prec3_hold();
        int nd, dc, ac;
        model_push(2'd3, 2'd0, 1'b0, 1'b0);
        model_push(2'd1, 2'd0, 1'b0, 1'b1);
        issue(2'd3, 2'd0, 1'b0, 1'b0, 1'b1);
        bus.i_prec   = 2'd1;
        bus.w_prec   = 2'd0;
        bus.i_signed = 1'b0;
        bus.w_signed = 1'b1;
        drain(1'b0, 0, 2, nd, dc, ac);
        total++;
        if (nd != 2 || dc != 5 || ac != 6) begin
            bad++;
            $display("FAIL p3_hold: got n=%0d dc=%0d acc=%0d want 2 5 6",
                     nd, dc, ac);
        end
    endtask

    task automatic test_async_reset();
        int nd, dc, ac;
        model_push(2'd2, 2'd2, 1'b0, 1'b0);
        issue(2'd2, 2'd2, 1'b0, 1'b0, 1'b0);
        drain(1'b0, 4, 0, nd, dc, ac);
        @(negedge clk);
        total++;
        if (bus.beat_valid !== 1'b1 || bus.i_slice !== 2'd0 ||
            bus.w_slice !== 2'd1) begin
            bad++;
            $display("FAIL rst_beat5: got v=%b i=%0d w=%0d want 1 0 1",
                     bus.beat_valid, bus.i_slice, bus.w_slice);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (idle_vec() !== 15'h4000) begin
            bad++;
            $display("FAIL rst_mid: got %h want 4000", idle_vec());
        end
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            total++;
            if (bus.done !== 1'b0 || bus.beat_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_hold: got done=%b v=%b want 0 0",
                         bus.done, bus.beat_valid);
            end
        end
        rst_n = 1'b1;
        model_push(2'd0, 2'd0, 1'b0, 1'b0);
        issue(2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        drain(1'b0, 0, 1, nd, dc, ac);
        total++;
        if (nd != 1 || dc != 2) begin
            bad++;
            $display("FAIL rst_rerun: got n=%0d cyc=%0d want n=1 cyc=2",
                     nd, dc);
        end
    endtask

    initial begin
        bus.job_valid  = 1'b0;
        bus.i_prec     = 2'd0;
        bus.w_prec     = 2'd0;
        bus.i_signed   = 1'b0;
        bus.w_signed   = 1'b0;
        bus.beat_ready = 1'b1;
        test_reset();
        test_unsigned_2b();
        test_signed_4b();
        test_8x2();
        test_8x8_stall();
        test_prec3_hold();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
